// File: rtl/demo_triangle_gen.sv
// Triangle-wave pattern source: ramps o_out between MIN_VAL and MAX_VAL in STEP
// increments, dwelling HOLD enabled cycles at each peak; frozen while i_enable is low.
//
// state   | meaning
// --------+-------------------------------------------------------------
// UP      | ramping up by STEP, clamps to MAX_VAL at the top
// HOLD_HI | dwelling at MAX_VAL for HOLD enabled edges
// DOWN    | ramping down by STEP, clamps to MIN_VAL at the bottom
// HOLD_LO | dwelling at MIN_VAL for HOLD enabled edges
module demo_triangle_gen #(
  parameter int WIDTH   = 8,
  parameter int STEP    = 1,
  parameter int MIN_VAL = 0,
  parameter int MAX_VAL = 255,
  parameter int HOLD    = 2
) (
  input  logic             i_clk,
  input  logic             i_rst_n,
  input  logic             i_enable,
  output logic [WIDTH-1:0] o_out
);

  localparam int CW = (HOLD > 0) ? $clog2(HOLD + 1) : 1;
  localparam int AW = WIDTH + 1;

  localparam logic [AW-1:0]    STEP_A   = AW'(STEP);
  localparam logic [AW-1:0]    MAX_A    = AW'(MAX_VAL);
  localparam logic [AW-1:0]    LO_THR_A = AW'(MIN_VAL + STEP);
  localparam logic [WIDTH-1:0] STEP_W   = WIDTH'(STEP);
  localparam logic [WIDTH-1:0] MIN_W    = WIDTH'(MIN_VAL);
  localparam logic [WIDTH-1:0] MAX_W    = WIDTH'(MAX_VAL);
  localparam logic [CW-1:0]    CNT_LAST = CW'((HOLD > 0) ? HOLD - 1 : 0);

  typedef enum logic [1:0] {
    UP      = 2'd0,
    HOLD_HI = 2'd1,
    DOWN    = 2'd2,
    HOLD_LO = 2'd3
  } state_t;

  state_t           r_state;
  state_t           w_state_nxt;
  logic [WIDTH-1:0] r_out;
  logic [WIDTH-1:0] w_out_nxt;
  logic [CW-1:0]    r_cnt;
  logic [CW-1:0]    w_cnt_nxt;
  logic [AW-1:0]    w_out_ext;
  logic [AW-1:0]    w_sum;

  // One extra bit so the peak compare cannot be fooled by wrap-around.
  assign w_out_ext = {1'b0, r_out};
  assign w_sum     = w_out_ext + STEP_A;

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      r_state <= UP;
      r_out   <= MIN_W;
      r_cnt   <= '0;
    end else begin
      r_state <= w_state_nxt;
      r_out   <= w_out_nxt;
      r_cnt   <= w_cnt_nxt;
    end
  end

  always_comb begin
    w_state_nxt = r_state;
    w_out_nxt   = r_out;
    w_cnt_nxt   = r_cnt;
    if (i_enable) begin
      case (r_state)
        UP: begin
          if (w_sum >= MAX_A) begin
            w_out_nxt   = MAX_W;
            w_cnt_nxt   = '0;
            w_state_nxt = (HOLD > 0) ? HOLD_HI : DOWN;
          end else begin
            w_out_nxt = w_sum[WIDTH-1:0];
          end
        end
        HOLD_HI: begin
          if (r_cnt == CNT_LAST) w_state_nxt = DOWN;
          else                   w_cnt_nxt   = r_cnt + 1'b1;
        end
        DOWN: begin
          // Subtraction only happens above MIN_VAL+STEP, so it cannot underflow.
          if (w_out_ext <= LO_THR_A) begin
            w_out_nxt   = MIN_W;
            w_cnt_nxt   = '0;
            w_state_nxt = (HOLD > 0) ? HOLD_LO : UP;
          end else begin
            w_out_nxt = r_out - STEP_W;
          end
        end
        HOLD_LO: begin
          if (r_cnt == CNT_LAST) w_state_nxt = UP;
          else                   w_cnt_nxt   = r_cnt + 1'b1;
        end
        default: w_state_nxt = UP;
      endcase
    end
  end

  assign o_out = r_out;

endmodule

// File: tb/tb_demo_triangle_gen.sv
// Bench for demo_triangle_gen: hand sequences on the default instance, a vector
// table on two small no-dwell instances, then random enable/reset against a waveform model.
module tb_demo_triangle_gen;

  logic       clk = 1'b0;
  logic       rst_a = 1'b0;
  logic       en_a = 1'b0;
  logic [7:0] out_a;
  logic       rst_bc = 1'b0;
  logic       en_b = 1'b0;
  logic       en_c = 1'b0;
  logic [7:0] out_b;
  logic [7:0] out_c;

  int checks = 0;
  int failures = 0;

  always #5 clk = ~clk;

  demo_triangle_gen u_a (
    .i_clk(clk), .i_rst_n(rst_a), .i_enable(en_a), .o_out(out_a)
  );

  demo_triangle_gen #(.WIDTH(8), .STEP(7), .MIN_VAL(0), .MAX_VAL(20), .HOLD(0)) u_b (
    .i_clk(clk), .i_rst_n(rst_bc), .i_enable(en_b), .o_out(out_b)
  );

  demo_triangle_gen #(.WIDTH(8), .STEP(1), .MIN_VAL(0), .MAX_VAL(3), .HOLD(0)) u_c (
    .i_clk(clk), .i_rst_n(rst_bc), .i_enable(en_c), .o_out(out_c)
  );

  // Reference: one full period of samples per instance, listed as the sequence of
  // values produced on successive enabled edges after reset.
  int wave [3][1024];
  int wlen [3];
  int ptr  [3];
  int mdl  [3];
  int mins [3];

  task automatic build(input int idx, input int mn, input int mx, input int st, input int hd);
    int v;
    int n;
    n = 0;
    v = mn;
    while (v != mx) begin
      v = (v + st > mx) ? mx : v + st;
      wave[idx][n] = v; n++;
    end
    for (int i = 0; i < hd; i++) begin wave[idx][n] = mx; n++; end
    while (v != mn) begin
      v = (v - st < mn) ? mn : v - st;
      wave[idx][n] = v; n++;
    end
    for (int i = 0; i < hd; i++) begin wave[idx][n] = mn; n++; end
    wlen[idx] = n;
    mins[idx] = mn;
  endtask

  task automatic model_edge(input int idx, input logic rst_n, input logic en);
    if (!rst_n) begin
      ptr[idx] = 0;
      mdl[idx] = mins[idx];
    end else if (en) begin
      mdl[idx] = wave[idx][ptr[idx]];
      ptr[idx] = (ptr[idx] + 1) % wlen[idx];
    end
  endtask

  task automatic check(input string name, input int act, input int exp);
    checks++;
    if (act != exp) begin
      failures++;
      $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  function automatic int exp_default(input int e);
    if (e <= 255) return e;
    if (e <= 257) return 255;
    if (e <= 512) return 512 - e;
    if (e <= 514) return 0;
    return e - 514;
  endfunction

  typedef struct {
    logic rst_n;
    logic en;
    int   exp_b;
    int   exp_c;
  } vec_t;

  vec_t vecs [12];

  initial begin
    vecs[0]  = '{1'b1, 1'b1,  7, 1};
    vecs[1]  = '{1'b1, 1'b1, 14, 2};
    vecs[2]  = '{1'b1, 1'b1, 20, 3};
    vecs[3]  = '{1'b1, 1'b1, 13, 2};
    vecs[4]  = '{1'b1, 1'b1,  6, 1};
    vecs[5]  = '{1'b1, 1'b1,  0, 0};
    vecs[6]  = '{1'b1, 1'b1,  7, 1};
    vecs[7]  = '{1'b1, 1'b0,  7, 1};
    vecs[8]  = '{1'b1, 1'b1, 14, 2};
    vecs[9]  = '{1'b0, 1'b1,  0, 0};
    vecs[10] = '{1'b1, 1'b1,  7, 1};
    vecs[11] = '{1'b1, 1'b1, 14, 2};

    build(0, 0, 255, 1, 2);
    build(1, 0, 20, 7, 0);
    build(2, 0, 3, 1, 0);

    // Reset held with enable high, including before any clock edge.
    en_a = 1'b1;
    #1;
    check("reset_pre_edge", out_a, 0);
    step(); check("reset_hold1", out_a, 0);
    step(); check("reset_hold2", out_a, 0);
    rst_a = 1'b1;

    // Full default period, counted in enabled edges since release.
    for (int e = 1; e <= 515; e++) begin
      step();
      check($sformatf("full_edge%0d", e), out_a, exp_default(e));
    end

    // Enable gating mid-ramp.
    rst_a = 1'b0; step(); rst_a = 1'b1;
    for (int i = 0; i < 40; i++) step();
    check("gate_at40", out_a, 40);
    en_a = 1'b0;
    for (int i = 0; i < 7; i++) begin step(); check("gate_hold40", out_a, 40); end
    en_a = 1'b1;
    step(); check("gate_resume41", out_a, 41);

    // Enable gating mid-dwell: still exactly two enabled edges at the top.
    for (int i = 0; i < 214; i++) step();
    check("peak_reach", out_a, 255);
    step(); check("dwell_edge1", out_a, 255);
    en_a = 1'b0;
    for (int i = 0; i < 5; i++) begin step(); check("dwell_gated", out_a, 255); end
    en_a = 1'b1;
    step(); check("dwell_edge2", out_a, 255);
    step(); check("dwell_exit", out_a, 254);

    // Asynchronous reset while ramping down.
    for (int i = 0; i < 154; i++) step();
    check("down_at100", out_a, 100);
    rst_a = 1'b0;
    #1;
    check("async_reset_immediate", out_a, 0);
    step(); check("async_reset_edge", out_a, 0);
    rst_a = 1'b1;
    step(); check("after_reset_first", out_a, 1);
    step(); check("after_reset_second", out_a, 2);
    en_a = 1'b0;

    // Clamp and no-dwell instances driven from the vector table.
    rst_bc = 1'b1;
    for (int i = 0; i < 12; i++) begin
      rst_bc = vecs[i].rst_n;
      en_b   = vecs[i].en;
      en_c   = vecs[i].en;
      step();
      check($sformatf("vec%0d_clamp", i), out_b, vecs[i].exp_b);
      check($sformatf("vec%0d_nodwell", i), out_c, vecs[i].exp_c);
    end

    // Random enable / reset against the waveform model.
    rst_a = 1'b0; rst_bc = 1'b0; en_a = 1'b0; en_b = 1'b0; en_c = 1'b0;
    step();
    for (int k = 0; k < 3; k++) model_edge(k, 1'b0, 1'b0);
    for (int n = 0; n < 3000; n++) begin
      logic r;
      r      = ($urandom_range(0, 199) != 0);
      rst_a  = r;
      rst_bc = r;
      en_a   = ($urandom_range(0, 9) < 8);
      en_b   = ($urandom_range(0, 9) < 6);
      en_c   = ($urandom_range(0, 9) < 5);
      step();
      model_edge(0, r, en_a);
      model_edge(1, r, en_b);
      model_edge(2, r, en_c);
      check("rand_default", out_a, mdl[0]);
      check("rand_clamp", out_b, mdl[1]);
      check("rand_nodwell", out_c, mdl[2]);
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/demo_triangle_gen.md
# demo_triangle_gen

Parameterised triangle-wave generator driving an 8-bit output bus. While enabled, it ramps `out` up from `MIN_VAL` to `MAX_VAL` and back down in `STEP` increments. It dwells `HOLD` cycles at each peak. It is a self-contained stimulus/pattern source for downstream datapath and bring-up logic, and it is frozen whenever `enable` is low.

## Interface
- `WIDTH`, default 8: output width; `out` is `WIDTH` bits.
- `STEP`, default 1: increment/decrement per active cycle; legal range 1 to `MAX_VAL-MIN_VAL`.
- `MIN_VAL`, default 0: lower peak; must satisfy `MIN_VAL < MAX_VAL`.
- `MAX_VAL`, default 255: upper peak; must be ≤ 2^`WIDTH`-1.
- `HOLD`, default 2: extra enabled cycles spent at each peak; 0 means no dwell.
- `clk`, input, 1: sole clock; all state updates on its rising edge.
- `reset`, input, 1: asynchronous, active-low reset.
  - Asserted when 0, acting immediately without waiting for a clock edge.
  - Deassertion is treated as synchronous to `clk` by the integrator.
- `enable`, input, 1: advance the generator on this rising edge when 1; hold all state when 0.
- `out`, output, `WIDTH`: current waveform sample, driven directly from a register.

## Operation
- The block has four states: `UP`, `HOLD_HI`, `DOWN`, `HOLD_LO`. It also has a dwell counter `cnt` of width clog2(`HOLD`+1), minimum 1 bit.
- While `reset` = 0:
  - `out` = `MIN_VAL`, state = `UP`, `cnt` = 0.
  - This applies immediately and remains in force for as long as `reset` is low.
- With `enable` = 0, the state, `out` and `cnt` all hold their values.
- All arithmetic is done at `WIDTH`+1 bits, so there is no wrap-around. `out` never leaves [`MIN_VAL`, `MAX_VAL`].
- `UP` state:
  - If `out`+`STEP` ≥ `MAX_VAL`: `out` ← `MAX_VAL` (clamped); `cnt` ← 0; next state `HOLD_HI` if `HOLD` > 0, else `DOWN`.
  - Otherwise `out` ← `out`+`STEP`.
- `HOLD_HI` state:
  - `out` unchanged.
  - If `cnt` = `HOLD`-1, next state is `DOWN`; otherwise `cnt` ← `cnt`+1.
- `DOWN` state:
  - If `out` < `MIN_VAL`+`STEP`, or equals it: `out` ← `MIN_VAL` (clamped); `cnt` ← 0; next state `HOLD_LO` if `HOLD` > 0, else `UP`.
  - Otherwise `out` ← `out`-`STEP`.
- `HOLD_LO` state: mirror of `HOLD_HI`, with next state `UP`.
- The clamp rule applies when `STEP` does not evenly divide the span: the peak value is always produced exactly.
- Unreachable state encodings recover to `UP` on the next enabled edge, with `out` unchanged.

## Timing
- Latency: `out` changes on the same rising edge on which `enable` = 1 is sampled. There is no pipeline delay.
- Reset mid-ramp: `out` returns to `MIN_VAL` asynchronously. The first enabled edge after release produces `MIN_VAL`+`STEP`.
- `enable` toggling mid-dwell: the dwell count only advances on enabled edges, so `HOLD` counts enabled cycles, not clock cycles.
- Period with `HOLD` = 0 and evenly divided span is 2·(`MAX_VAL`-`MIN_VAL`)/`STEP` enabled edges.
- Each `HOLD` adds `HOLD` edges per peak.

## Test plan
- **Reset:** hold `reset` = 0 for 2 cycles with `enable` = 1 → `out` = 0 throughout, including before the first clock edge. Release with `enable` = 1 → `out` = 1, 2, 3 on the next three edges.
- **Default full cycle** (STEP=1, HOLD=2), counting enabled edges after release:
  - Edges 1–255: `out` = 1..255; edges 256–257: `out` = 255.
  - Edge 258: 254; edge 512: 0; edges 513–514: 0; edge 515: 1.
- **Enable gating:** at `out` = 40 drop `enable` for 7 cycles → `out` stays 40; re-assert → 41.
  - Repeat during `HOLD_HI`: the dwell length is still exactly 2 enabled edges.
- **Async reset mid-ramp:** assert `reset` = 0 between edges while `out` = 100 in `DOWN` → `out` = 0 immediately, without a clock edge. After release, the first enabled edge gives 1 (state `UP`).
- **Clamp** (STEP=7, MIN=0, MAX=20, HOLD=0): `out` = 7, 14, 20, 13, 6, 0, 7 on successive enabled edges.
- **No dwell** (STEP=1, MAX=3, HOLD=0): `out` = 1, 2, 3, 2, 1, 0, 1.
